// File: rtl/clk_lock_monitor_pkg.sv
`default_nettype none
// ============================================================================
// clk_lock_monitor_pkg : state encoding shared with the register-bank readback
// Revision: 1.0
// ============================================================================
package clk_lock_monitor_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DCM_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_bit.sv
`default_nettype none
// ============================================================================
// cdc_sync_bit : multi-flop synchronizer for one asynchronous level
// Revision: 1.0
// ============================================================================
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/clk_lock_monitor.sv
`default_nettype none
// ============================================================================
// clk_lock_monitor : DCM lock supervisor; sequences DCM reset, qualifies lock
//                    stability and releases the system reset.
// Revision: 1.0
// ============================================================================
module clk_lock_monitor
  import clk_lock_monitor_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int DCM_RST_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 LOCKED_IN,
  input  logic                 CLR_CNT,
  output logic                 DCM_RST,
  output logic                 SYS_RST,
  output logic                 LOCK_OK,
  output logic [STATE_W-1:0]   STATE,
  output logic [CNT_WIDTH-1:0] LOSS_CNT,
  output logic [CNT_WIDTH-1:0] RETRY_CNT
);

  localparam int CNT_MAX = max3(LOCK_TIMEOUT, STABLE_CYCLES, DCM_RST_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0]        DCM_LAST     = CW'(DCM_RST_CYCLES - 1);
  localparam logic [CW-1:0]        TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]        STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]        CNT_ONE      = CW'(1);
  localparam logic [CNT_WIDTH-1:0] EVT_ONE      = CNT_WIDTH'(1);

  logic                 lock_s;
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 dcm_rst_q, sys_rst_q, lock_ok_q;
  logic [CNT_WIDTH-1:0] loss_q, loss_d, retry_q, retry_d;
  logic                 loss_inc, retry_inc;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (BUS_CLK),
    .rst_i  (BUS_RST),
    .d_i    (LOCKED_IN),
    .q_o    (lock_s)
  );

  // A clear coinciding with an event leaves that event counted.
  function automatic logic [CNT_WIDTH-1:0] sat_cnt(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 inc,
    input logic                 clr
  );
    if (clr) begin
      sat_cnt = inc ? EVT_ONE : '0;
    end else if (inc && (cur != '1)) begin
      sat_cnt = cur + EVT_ONE;
    end else begin
      sat_cnt = cur;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    loss_inc  = 1'b0;
    retry_inc = 1'b0;
    case (state_q)
      ST_DCM_RESET: begin
        if (cnt_q == DCM_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout on the same edge.
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_DCM_RESET;
          cnt_d     = '0;
          retry_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d  = ST_LOST;
          loss_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_DCM_RESET;
        cnt_d   = '0;
      end
    endcase
    loss_d  = sat_cnt(loss_q, loss_inc, CLR_CNT);
    retry_d = sat_cnt(retry_q, retry_inc, CLR_CNT);
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q   <= ST_DCM_RESET;
      cnt_q     <= '0;
      dcm_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      lock_ok_q <= 1'b0;
      loss_q    <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dcm_rst_q <= (state_d == ST_DCM_RESET);
      sys_rst_q <= (state_d != ST_RUN);
      lock_ok_q <= (state_d == ST_RUN);
      loss_q    <= loss_d;
      retry_q   <= retry_d;
    end
  end

  assign DCM_RST   = dcm_rst_q;
  assign SYS_RST   = sys_rst_q;
  assign LOCK_OK   = lock_ok_q;
  assign STATE     = state_q;
  assign LOSS_CNT  = loss_q;
  assign RETRY_CNT = retry_q;

endmodule
`default_nettype wire
